// File: rtl/comparador_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : comparador_pkg
// Description : Shared definitions for the bit-serial magnitude comparator.
//               Holds the FSM state encoding, the default word width and the
//               next-state equation of the running "A greater so far" flag.
// Revision    : 1.0 - initial release
// ============================================================================
package comparador_pkg;

    // Default operand width in bits.
    localparam int c_default_width = 8;

    // Controller states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One iterative comparison cell, evaluated right to left.
    // Equal bits keep x.
    // A differing bit overrides x, so later (more significant) bits win.
    function automatic logic x_next(input logic a, input logic b, input logic x);
        return (a & ~b) | (x & ~b) | (x & a);
    endfunction

endpackage : comparador_pkg
`default_nettype wire

// File: rtl/registro_desplazamiento.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : registro_desplazamiento
// Description : WIDTH-bit parallel-load, shift-right register with the LSB
//               presented as the serial output. Load has priority over shift.
// Ports       : clk     - clock
//               rst     - asynchronous active-high clear
//               i_load  - parallel load of i_data
//               i_shift - shift right by one, zero filled at the MSB
//               i_data  - parallel load value
//               o_ser   - current LSB
// Revision    : 1.0 - initial release
// ============================================================================
module registro_desplazamiento #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ser
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_ser = r_data[0];

endmodule : registro_desplazamiento
`default_nettype wire

// File: rtl/comparador_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : comparador_serial
// Description : Bit-serial magnitude comparator. Accepts two N-bit words on a
//               start/ready handshake, walks their bit pairs LSB first, and
//               reports the active-low result Z (0: A > B, 1: A <= B).
// Ports       : clk       - clock
//               reset     - asynchronous active-high reset
//               start     - compare request, honoured only while ready
//               A, B      - operands, sampled when start is accepted
//               ready     - idle and able to accept start
//               a_ser     - current A bit (LSB first)
//               b_ser     - current B bit
//               bit_valid - a_ser/b_ser carry a live bit pair
//               done      - one-cycle pulse, Z updated this cycle
//               Z         - active-low result, holds between comparisons
// Revision    : 1.0 - initial release
// ============================================================================
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int N = c_default_width
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         a_ser,
    output logic         b_ser,
    output logic         bit_valid,
    output logic         done,
    output logic         Z
);

    localparam int                 c_cnt_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_x;
    logic               r_ready;
    logic               r_done;
    logic               r_bit_valid;
    logic               r_z;

    logic               w_load;
    logic               w_shift;

    assign w_load  = (r_state == IDLE) && start;
    assign w_shift = (r_state == SHIFT);

    registro_desplazamiento #(.WIDTH(N)) u_reg_a (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (A),
        .o_ser   (a_ser)
    );

    registro_desplazamiento #(.WIDTH(N)) u_reg_b (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (B),
        .o_ser   (b_ser)
    );

    // Handshake outputs are registered from the state being entered, so they
    // line up with r_state on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x         <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_bit_valid <= 1'b0;
            r_z         <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= SHIFT;
                        r_x         <= 1'b0;
                        r_cnt       <= '0;
                        r_ready     <= 1'b0;
                        r_bit_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_x <= x_next(a_ser, b_ser, r_x);
                    // Counter stops at N-1 instead of overflowing; it is
                    // cleared again on the next load.
                    if (r_cnt == c_last) begin
                        r_state     <= DONE;
                        r_bit_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_z     <= ~r_x;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_ready     <= 1'b1;
                    r_bit_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign bit_valid = r_bit_valid;
    assign Z         = r_z;

endmodule : comparador_serial
`default_nettype wire
